dsp_systolic_27x27s_feeder: RTL and testbench
=============================================

Name: dsp_systolic_27x27s_feeder

Overview:
Operand-side front end for the 27x27 signed systolic dot-product chain (dsp_systolic_27x27s). It accepts one full NUM-lane operand vector per beat over valid/ready, and applies the triangular skew the chain needs: lane i is delayed i cycles, so one wavefront yields one true dot product. It tracks each wavefront through the fixed engine latency, captures the engine result into an output FIFO with backpressure, and returns it with its tag. It uses a credit limit so that no in-flight result is ever lost.

Parameters:
AX_WIDTH, 27, signed width of each ax lane
AY_WIDTH, 27, signed width of each ay lane
NUM, 10, number of lanes / chain length
PIPELINE, 3, engine PIPELINE parameter, which must match the engine instance
RESULT_A_WIDTH, 64, width of the accumulated result
TAG_WIDTH, 8, width of the user tag carried with each vector
FIFO_DEPTH, 16, output FIFO entries; must be >= DOT_LAT+2, checked by an elaboration assertion

Ports:
clk  in  1  clock
sclr  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  feeder can accept a vector
in_ax  in  NUM*AX_WIDTH  ax lanes, lane i at bits [i*AX_WIDTH +: AX_WIDTH], signed
in_ay  in  NUM*AY_WIDTH  ay lanes, same packing
in_tag  in  TAG_WIDTH  user tag
eng_ax  out  NUM*AX_WIDTH  skewed ax to the engine (engine ax[i] = lane i)
eng_ay  out  NUM*AY_WIDTH  skewed ay to the engine
eng_result  in  RESULT_A_WIDTH  engine result
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_result  out  RESULT_A_WIDTH  signed dot product
out_tag  out  TAG_WIDTH  tag of that vector

Behaviour:
- Constant DOT_LAT = NUM + PIPELINE - 1. If lane i of a wavefront is driven on eng_* in cycle t0+i, eng_result holds that wavefront's sum in cycle t0+DOT_LAT.
- Accept: a vector is accepted on a clk edge where in_valid && in_ready.
- Skew: lane 0 is registered, so it appears on eng_* in the cycle after acceptance. Lane i passes through i further register stages.
- Bubbles: when no vector is accepted, a zero is injected into every lane's first skew stage. Overlapping wavefronts from consecutive accepts never interfere; the engine chain carries each sum along its own wavefront.
- Valid/tag tracking: a shift register of depth DOT_LAT+1 carries {valid, tag} from acceptance to the cycle eng_result holds the sum. In that cycle {eng_result, tag} is written to the FIFO.
- FIFO: show-ahead. out_valid = not empty; out_result and out_tag show the head entry; the head pops on out_valid && out_ready.
- A write into an empty FIFO is visible on out_valid one cycle later.
- Simultaneous push and pop are allowed at any occupancy, including full.
- End-to-end latency: acceptance edge E gives out_valid high after edge E+DOT_LAT+2, assuming an empty FIFO.
- Credits: outstanding = in-flight wavefronts + FIFO occupancy. in_ready = (outstanding < FIFO_DEPTH), registered.
- A pop in cycle t frees a credit that is visible on in_ready at t+1. The FIFO therefore never overflows, and no write is ever dropped.
- Arithmetic: none in the feeder. The result is passed through unmodified. Worst case NUM*2^52 fits in 64 bits signed.
- Ordering: results leave strictly in acceptance order. Throughput is one vector per cycle when out_ready stays high.
- Reset (sclr, any time, including mid-stream) clears the following in the next cycle:
  - every skew stage to 0, so eng_ax = eng_ay = 0;
  - all valid bits and the credit count;
  - the FIFO (out_valid = 0).
- Reset values: out_result = 0 and out_tag = 0 are don't-care but are driven as 0. in_ready = 0 during sclr and 1 in the first cycle after it.
- Wavefronts in flight at reset are discarded. Results from stale engine state are never written, because their valid bits are cleared.
- The engine has no reset. Stale partial sums flush along their own wavefronts, so the first post-reset vector is correct.

Decomposition:
- Package dsp_systolic_pkg holds:
  - function dot_lat(NUM, PIPELINE);
  - localparams for the default widths;
  - typedef tag_t.
- Sub-module dsp_systolic_skew: triangular delay line, parameterised by lane count and lane width, synchronous clear. It is instantiated once for ax and once for ay.
- The FIFO and the credit counter stay inline.

Test Plan:
- Single vector, engine instanced with defaults: ax all lanes = 1, ay lane i = i+1, tag = 0x5A → out_result = 55 and out_tag = 0x5A. out_valid rises exactly DOT_LAT+2 edges after acceptance and holds until out_ready.
- Corner values: all lanes ax = ay = -2^26 → 10*2^52 = 45035996273704960. ax = -2^26, ay = 2^26-1 on all lanes → -10*(2^52-2^26).
- 200 back-to-back random vectors (tags 0..199), out_ready = 1 → in_ready never drops, one result per cycle, matching a reference model in tag order.
- Backpressure: out_ready = 0 with continuous in_valid → exactly FIFO_DEPTH vectors accepted, then in_ready = 0. Raising out_ready drains in order, and in_ready returns one cycle after the first pop.
- Random in_valid gaps (50%) and random out_ready (30%) over 2000 vectors → no loss, no duplication, all sums correct.
- sclr asserted for 1 cycle with 5 wavefronts in flight and 3 entries in the FIFO:
  - next cycle: out_valid = 0 and eng_ax = eng_ay = 0;
  - a vector sent right after reset returns the correct sum, and no stale result ever appears.

Source files
------------

// File: rtl/dsp_systolic_pkg.sv
// Shared widths, tag type and latency helper for the 27x27 signed systolic
// dot-product engine and its operand feeder.
package dsp_systolic_pkg;

  localparam int AX_WIDTH_DEF       = 27;
  localparam int AY_WIDTH_DEF       = 27;
  localparam int NUM_DEF            = 10;
  localparam int PIPELINE_DEF       = 3;
  localparam int RESULT_A_WIDTH_DEF = 64;
  localparam int TAG_WIDTH_DEF      = 8;
  localparam int FIFO_DEPTH_DEF     = 16;

  typedef logic [TAG_WIDTH_DEF-1:0] tag_t;

  // Cycles from lane 0 of a wavefront on the engine inputs to its sum on eng_result.
  function automatic int dot_lat(input int num, input int pipeline);
    return num + pipeline - 1;
  endfunction

endpackage

// File: rtl/dsp_systolic_skew.sv
// Triangular delay line: lane i is delayed by i+1 register stages, so one
// accepted beat leaves as a diagonal wavefront. Synchronous clear zeroes every stage.
module dsp_systolic_skew #(
  parameter int LANES = 10,
  parameter int WIDTH = 27
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [LANES*WIDTH-1:0] din,
  output logic [LANES*WIDTH-1:0] dout
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] stage_r [0:i];

    // Shift lane i through its i+1 stages.
    always_ff @(posedge clk) begin
      if (clr) begin
        for (int k = 0; k <= i; k++) stage_r[k] <= {WIDTH{1'b0}};
      end else begin
        stage_r[0] <= din[i*WIDTH +: WIDTH];
        for (int k = 1; k <= i; k++) stage_r[k] <= stage_r[k-1];
      end
    end

    assign dout[i*WIDTH +: WIDTH] = stage_r[i];
  end

endmodule

// File: rtl/dsp_systolic_27x27s_feeder.sv
// Operand feeder for the systolic dot-product chain: skews accepted vectors,
// tracks each wavefront to its result, and returns {result, tag} through a credited FIFO.
module dsp_systolic_27x27s_feeder
  import dsp_systolic_pkg::*;
#(
  parameter int AX_WIDTH       = AX_WIDTH_DEF,
  parameter int AY_WIDTH       = AY_WIDTH_DEF,
  parameter int NUM            = NUM_DEF,
  parameter int PIPELINE       = PIPELINE_DEF,
  parameter int RESULT_A_WIDTH = RESULT_A_WIDTH_DEF,
  parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      sclr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM*AX_WIDTH-1:0]   in_ax,
  input  logic [NUM*AY_WIDTH-1:0]   in_ay,
  input  logic [TAG_WIDTH-1:0]      in_tag,
  output logic [NUM*AX_WIDTH-1:0]   eng_ax,
  output logic [NUM*AY_WIDTH-1:0]   eng_ay,
  input  logic [RESULT_A_WIDTH-1:0] eng_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RESULT_A_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]      out_tag
);

  localparam int DOT_LAT = dot_lat(NUM, PIPELINE);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < DOT_LAT + 2) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least DOT_LAT+2");
  end

  logic                      in_ready_r, accept_s, push_s, pop_s;
  logic [NUM*AX_WIDTH-1:0]   skew_ax_s;
  logic [NUM*AY_WIDTH-1:0]   skew_ay_s;
  logic [DOT_LAT:0]          trk_valid_r;
  logic [TAG_WIDTH-1:0]      trk_tag_r [0:DOT_LAT];
  logic [RESULT_A_WIDTH-1:0] mem_res_r [0:FIFO_DEPTH-1];
  logic [TAG_WIDTH-1:0]      mem_tag_r [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r, wr_next_s, rd_next_s;
  logic [CNT_W-1:0]          fifo_cnt_r, fifo_cnt_next_s, avail_s, credit_r, credit_next_s;
  logic                      out_valid_r;
  logic [RESULT_A_WIDTH-1:0] out_result_r;
  logic [TAG_WIDTH-1:0]      out_tag_r;

  // in_ready is forced low while sclr is held so nothing is accepted into a clearing pipe.
  assign in_ready = in_ready_r & ~sclr;
  assign accept_s = in_valid & in_ready;
  assign push_s   = trk_valid_r[DOT_LAT];
  assign pop_s    = out_valid_r & out_ready;

  // Bubbles inject zeros so idle cycles add nothing to neighbouring wavefronts.
  always_comb begin
    if (accept_s) begin
      skew_ax_s = in_ax;
      skew_ay_s = in_ay;
    end else begin
      skew_ax_s = {(NUM*AX_WIDTH){1'b0}};
      skew_ay_s = {(NUM*AY_WIDTH){1'b0}};
    end
  end

  dsp_systolic_skew #(.LANES(NUM), .WIDTH(AX_WIDTH)) u_skew_ax (
    .clk(clk), .clr(sclr), .din(skew_ax_s), .dout(eng_ax)
  );

  dsp_systolic_skew #(.LANES(NUM), .WIDTH(AY_WIDTH)) u_skew_ay (
    .clk(clk), .clr(sclr), .din(skew_ay_s), .dout(eng_ay)
  );

  // Carry {valid, tag} alongside each wavefront until its sum is on eng_result.
  always_ff @(posedge clk) begin
    if (sclr) begin
      trk_valid_r <= {(DOT_LAT+1){1'b0}};
      for (int k = 0; k <= DOT_LAT; k++) trk_tag_r[k] <= {TAG_WIDTH{1'b0}};
    end else begin
      trk_valid_r  <= {trk_valid_r[DOT_LAT-1:0], accept_s};
      trk_tag_r[0] <= in_tag;
      for (int k = 1; k <= DOT_LAT; k++) trk_tag_r[k] <= trk_tag_r[k-1];
    end
  end

  // Next pointers, occupancy and credit count.
  always_comb begin
    if (pop_s) begin
      rd_next_s = (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_next_s = (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_ONE;
    end else begin
      wr_next_s = wr_ptr_r;
    end
    fifo_cnt_next_s = fifo_cnt_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    // Entries already stored before this edge's write: the show-ahead view lags a write by one cycle.
    avail_s         = fifo_cnt_r - {{(CNT_W-1){1'b0}}, pop_s};
    credit_next_s   = credit_r + {{(CNT_W-1){1'b0}}, accept_s} - {{(CNT_W-1){1'b0}}, pop_s};
  end

  // FIFO storage; a push while full only happens alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_res_r[wr_ptr_r] <= eng_result;
      mem_tag_r[wr_ptr_r] <= trk_tag_r[DOT_LAT];
    end
  end

  // FIFO control, registered head view and credit-based ready.
  always_ff @(posedge clk) begin
    if (sclr) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      fifo_cnt_r   <= {CNT_W{1'b0}};
      credit_r     <= {CNT_W{1'b0}};
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_result_r <= {RESULT_A_WIDTH{1'b0}};
      out_tag_r    <= {TAG_WIDTH{1'b0}};
    end else begin
      rd_ptr_r    <= rd_next_s;
      wr_ptr_r    <= wr_next_s;
      fifo_cnt_r  <= fifo_cnt_next_s;
      credit_r    <= credit_next_s;
      in_ready_r  <= (credit_next_s < DEPTH_C);
      out_valid_r <= (avail_s != {CNT_W{1'b0}});
      if (avail_s != {CNT_W{1'b0}}) begin
        out_result_r <= mem_res_r[rd_next_s];
        out_tag_r    <= mem_tag_r[rd_next_s];
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_tag    = out_tag_r;

endmodule

// File: tb/tb_dsp_systolic_27x27s_feeder.sv
// Bench for the systolic feeder: behavioural engine model on eng_*, table-driven
// directed vectors, and a scoreboard for streaming, backpressure and reset scenarios.
module tb_dsp_systolic_27x27s_feeder;
  import dsp_systolic_pkg::*;

  localparam int AXW = 27, AYW = 27, NUM = 10, PIPELINE = 3, RW = 64, TW = 8, DEPTH = 16;
  localparam int DOT_LAT = NUM + PIPELINE - 1;

  logic                clk, sclr, in_valid, in_ready, out_valid, out_ready;
  logic [NUM*AXW-1:0]  in_ax, eng_ax;
  logic [NUM*AYW-1:0]  in_ay, eng_ay;
  logic [TW-1:0]       in_tag, out_tag;
  logic [RW-1:0]       eng_result, out_result;

  dsp_systolic_27x27s_feeder #(
    .AX_WIDTH(AXW), .AY_WIDTH(AYW), .NUM(NUM), .PIPELINE(PIPELINE),
    .RESULT_A_WIDTH(RW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .sclr(sclr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ax(in_ax), .in_ay(in_ay), .in_tag(in_tag),
    .eng_ax(eng_ax), .eng_ay(eng_ay), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint lane_ax(input logic [NUM*AXW-1:0] v, input int i);
    return longint'($signed(v[i*AXW +: AXW]));
  endfunction

  function automatic longint lane_ay(input logic [NUM*AYW-1:0] v, input int i);
    return longint'($signed(v[i*AYW +: AYW]));
  endfunction

  function automatic longint dot(input logic [NUM*AXW-1:0] a, input logic [NUM*AYW-1:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < NUM; i++) s += lane_ax(a, i) * lane_ay(b, i);
    return s;
  endfunction

  // Engine model: lane i of a wavefront seen in cycle t0+i contributes to eng_result in cycle t0+DOT_LAT.
  logic [NUM*AXW-1:0] hax [0:DOT_LAT-1];
  logic [NUM*AYW-1:0] hay [0:DOT_LAT-1];

  function automatic longint eng_sum();
    longint s;
    s = 0;
    for (int i = 0; i < NUM; i++)
      s += lane_ax(hax[DOT_LAT-2-i], i) * lane_ay(hay[DOT_LAT-2-i], i);
    return s;
  endfunction

  always @(posedge clk) begin
    eng_result <= eng_sum();
    hax[0] <= eng_ax;
    hay[0] <= eng_ay;
    for (int k = 1; k < DOT_LAT; k++) begin
      hax[k] <= hax[k-1];
      hay[k] <= hay[k-1];
    end
  end

  typedef struct {
    logic [NUM*AXW-1:0] ax;
    logic [NUM*AYW-1:0] ay;
    logic [TW-1:0]      tag;
    longint             exp;
  } vec_t;

  typedef struct {
    tag_t   tag;
    longint res;
  } sb_t;

  vec_t tbl [6];
  sb_t  sb [$];
  int   checks, errors, cyc, n_acc, n_pop, acc_edge, pop_mark, acc_mark;
  int   first_pop_edge, last_pop_edge, stalls, guard;

  function automatic logic [NUM*AXW-1:0] ramp_ax(input longint base, input longint step);
    logic [NUM*AXW-1:0] r;
    longint v;
    r = '0;
    for (int i = 0; i < NUM; i++) begin
      v = base + step * i;
      r[i*AXW +: AXW] = v[AXW-1:0];
    end
    return r;
  endfunction

  function automatic logic [NUM*AYW-1:0] ramp_ay(input longint base, input longint step);
    logic [NUM*AYW-1:0] r;
    longint v;
    r = '0;
    for (int i = 0; i < NUM; i++) begin
      v = base + step * i;
      r[i*AYW +: AYW] = v[AYW-1:0];
    end
    return r;
  endfunction

  task automatic rand_inputs();
    logic [31:0] u;
    for (int i = 0; i < NUM; i++) begin
      u = $urandom();
      in_ax[i*AXW +: AXW] = u[AXW-1:0];
      u = $urandom();
      in_ay[i*AYW +: AYW] = u[AYW-1:0];
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshakes that will complete at the coming rising edge.
  task automatic observe();
    sb_t e;
    if (sclr) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back('{tag: in_tag, res: dot(in_ax, in_ay)});
        acc_edge = cyc + 1;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (n_pop == pop_mark) first_pop_edge = cyc + 1;
        last_pop_edge = cyc + 1;
        n_pop++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_result", longint'(out_tag), -1);
        end else begin
          e = sb.pop_front();
          chk("sb_result", out_result, e.res);
          chk("sb_tag", longint'(out_tag), longint'(e.tag));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_valid(input int bound);
    int k;
    k = 0;
    while (!out_valid && k < bound) begin
      tick();
      k++;
    end
    chk("wait_out_valid", longint'(out_valid), 1);
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && k < bound) begin
      tick();
      k++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    tbl[0] = '{ax: ramp_ax(1, 0),         ay: ramp_ay(1, 1),         tag: 8'h5A, exp: 64'sd55};
    tbl[1] = '{ax: ramp_ax(-67108864, 0), ay: ramp_ay(-67108864, 0), tag: 8'h11, exp: 64'sd45035996273704960};
    tbl[2] = '{ax: ramp_ax(-67108864, 0), ay: ramp_ay(67108863, 0),  tag: 8'h22, exp: -64'sd45035995602616320};
    tbl[3] = '{ax: ramp_ax(67108863, 0),  ay: ramp_ay(67108863, 0),  tag: 8'h33, exp: 64'sd45035994931527690};
    tbl[4] = '{ax: ramp_ax(0, 0),         ay: ramp_ay(5, 0),         tag: 8'hFF, exp: 64'sd0};
    tbl[5] = '{ax: ramp_ax(-5, 1),        ay: ramp_ay(-3, 0),        tag: 8'h01, exp: 64'sd15};

    checks = 0; errors = 0; cyc = 0; n_acc = 0; n_pop = 0; acc_edge = 0; pop_mark = 0;
    sclr = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ax = '0; in_ay = '0; in_tag = '0;

    repeat (3) tick();
    chk("rst_in_ready_during_sclr", longint'(in_ready), 0);
    sclr = 1'b0;
    #1;
    chk("rst_in_ready_after", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    chk("rst_eng_ax_zero", longint'(eng_ax == '0), 1);

    // Directed vectors: latency, hold under out_ready low, value and pop.
    foreach (tbl[n]) begin
      pop_mark = n_pop;
      in_ax = tbl[n].ax; in_ay = tbl[n].ay; in_tag = tbl[n].tag; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_ax = '0; in_ay = '0;
      wait_valid(40);
      chk("tbl_latency", cyc - acc_edge, DOT_LAT + 2);
      chk("tbl_result", out_result, tbl[n].exp);
      chk("tbl_tag", longint'(out_tag), longint'(tbl[n].tag));
      repeat (3) tick();
      chk("tbl_hold_valid", longint'(out_valid), 1);
      chk("tbl_hold_result", out_result, tbl[n].exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("tbl_popped", longint'(out_valid), 0);
      chk("tbl_pop_count", n_pop - pop_mark, 1);
    end

    // 200 back-to-back vectors with out_ready held high.
    out_ready = 1'b1; stalls = 0; pop_mark = n_pop; acc_mark = n_acc;
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      in_tag = 8'(n);
      in_valid = 1'b1;
      if (!in_ready) stalls++;
      tick();
    end
    drain(100);
    chk("b2b_stalls", stalls, 0);
    chk("b2b_accepted", n_acc - acc_mark, 200);
    chk("b2b_results", n_pop - pop_mark, 200);
    chk("b2b_rate", last_pop_edge - first_pop_edge, 199);

    // Backpressure: credits stop acceptance at DEPTH, first pop reopens in_ready.
    out_ready = 1'b0; pop_mark = n_pop; acc_mark = n_acc;
    for (int n = 0; n < 45; n++) begin
      rand_inputs();
      in_tag = 8'(n);
      in_valid = 1'b1;
      tick();
    end
    chk("bp_accepted", n_acc - acc_mark, DEPTH);
    chk("bp_in_ready_low", longint'(in_ready), 0);
    chk("bp_out_valid", longint'(out_valid), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_credit_return", longint'(in_ready), 1);
    drain(100);
    chk("bp_results", n_pop - pop_mark, DEPTH);

    // Random valid gaps and sparse out_ready over 2000 vectors.
    pop_mark = n_pop; acc_mark = n_acc; guard = 0;
    while (n_acc - acc_mark < 2000 && guard < 30000) begin
      rand_inputs();
      in_tag = 8'(n_acc - acc_mark);
      in_valid = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 3);
      tick();
      guard++;
    end
    drain(200);
    chk("rnd_accepted", n_acc - acc_mark, 2000);
    chk("rnd_results", n_pop - pop_mark, 2000);

    // Mid-stream reset with 5 wavefronts in flight and 3 results queued.
    out_ready = 1'b0;
    for (int n = 0; n < 8; n++) begin
      rand_inputs();
      in_tag = 8'(8'hA0 + n);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    chk("pre_rst_out_valid", longint'(out_valid), 1);
    sclr = 1'b1;
    #1;
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    tick();
    sclr = 1'b0;
    chk("post_rst_out_valid", longint'(out_valid), 0);
    chk("post_rst_eng_ax", longint'(eng_ax == '0), 1);
    chk("post_rst_eng_ay", longint'(eng_ay == '0), 1);
    #1;
    chk("post_rst_in_ready", longint'(in_ready), 1);
    pop_mark = n_pop;
    in_ax = tbl[0].ax; in_ay = tbl[0].ay; in_tag = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(40);
    chk("post_rst_result", out_result, 55);
    chk("post_rst_tag", longint'(out_tag), 8'h77);
    drain(60);
    repeat (30) tick();
    chk("post_rst_no_stale", n_pop - pop_mark, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
